// File: rtl/rd_xfr_sequencer.sv
// -----------------------------------------------------------------------------
// rd_xfr_sequencer
//
// Readout controller for the radio-detector (RD) serial link. A trigger
// request from the UUB trigger logic becomes a TRIGGER pulse to the RD. The
// block then waits, with a timeout, for the RD to raise ENABLE_XFR. While
// ENABLE_XFR is high it deframes two 13-bit serial streams: 12 data bits
// MSB-first, then one odd-parity bit. It counts complete words and per-channel
// parity errors, reports DONE or an error, and enforces a holdoff before the
// next trigger is accepted.
//
// Parameters
//   MEM_SIZE     words per channel in a complete transfer
//   TRIG_WIDTH   TRIGGER high time in CLK cycles (>= 1)
//   ACK_TIMEOUT  maximum cycles from TRIGGER rise to ENABLE_XFR = 1
//   HOLDOFF      dead cycles after a transfer end or error (>= 1)
//
// Ports
//   CLK, RESET      clock; synchronous active-high reset
//   ENABLE          software enable; 0 forces IDLE and keeps the status
//   TRIG_REQ        one-cycle trigger request
//   ENABLE_XFR      RD transfer frame, synchronous and aligned with SERIAL_IN*
//   SERIAL_IN0/1    RD serial data, channels 0 and 1
//   TRIGGER         trigger to the RD
//   BUSY            1 in every state except IDLE
//   DONE            pulse: exactly MEM_SIZE words received
//   TIMEOUT_ERR     pulse: no ENABLE_XFR within ACK_TIMEOUT cycles
//   LEN_ERR         pulse: frame ended early, or ran past MEM_SIZE words
//   TRIG_DROP       pulse: a TRIG_REQ was ignored
//   WORD_COUNT      complete words in the current or last transfer
//   PAR_ERR0/1      saturating parity error counts per channel
//
// Optional outputs, present only when RD_SEQ_DATA_OUT_EN is defined:
//   RD_DATA0/1      deserialized 12-bit words
//   RD_PAR_OK       parity result per channel ([0] = ch0, [1] = ch1)
//   RD_ADDR         0-based index of the word
//   RD_VALID        strobe in the cycle after each counted parity bit
// -----------------------------------------------------------------------------
module rd_xfr_sequencer #(
  parameter int MEM_SIZE    = 2048,
  parameter int TRIG_WIDTH  = 4,
  parameter int ACK_TIMEOUT = 1024,
  parameter int HOLDOFF     = 16
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        ENABLE,
  input  logic                        TRIG_REQ,
  input  logic                        ENABLE_XFR,
  input  logic                        SERIAL_IN0,
  input  logic                        SERIAL_IN1,
  output logic                        TRIGGER,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        TIMEOUT_ERR,
  output logic                        LEN_ERR,
  output logic                        TRIG_DROP,
  output logic [$clog2(MEM_SIZE):0]   WORD_COUNT,
  output logic [15:0]                 PAR_ERR0,
`ifdef RD_SEQ_DATA_OUT_EN
  output logic [15:0]                 PAR_ERR1,
  output logic [11:0]                 RD_DATA0,
  output logic [11:0]                 RD_DATA1,
  output logic [1:0]                  RD_PAR_OK,
  output logic [$clog2(MEM_SIZE)-1:0] RD_ADDR,
  output logic                        RD_VALID
`else
  output logic [15:0]                 PAR_ERR1
`endif
);

  localparam int WC_W   = $clog2(MEM_SIZE) + 1;
  localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);
  localparam int PH_MAX = (TRIG_WIDTH > HOLDOFF) ? TRIG_WIDTH : HOLDOFF;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [WC_W-1:0] WC_FULL  = WC_W'(MEM_SIZE);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [PH_W-1:0] TW_LAST  = PH_W'(TRIG_WIDTH - 1);
  localparam logic [PH_W-1:0] HO_LAST  = PH_W'(HOLDOFF - 1);
  localparam logic [3:0]      PAR_BIT  = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_XFR,
    S_XFR,
    S_HOLD
  } state_t;

  state_t state_q, state_d;

  logic [PH_W-1:0] phase_cnt;   // cycles spent in the current state
  logic [TO_W-1:0] tmo_cnt;     // cycles since TRIG entry
  logic [3:0]      bit_cnt;     // position inside the 13-bit frame
  logic            overrun;     // frame ran past MEM_SIZE words
  logic            par0, par1;  // running XOR of the data bits

`ifdef RD_SEQ_DATA_OUT_EN
  logic [11:0]     sh0, sh1;
`endif

  logic start;
  logic sample;
  logic word_end;
  logic ovr_start;
  logic done_d;
  logic len_d;
  logic tmo_d;
  logic drop_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next state and the one-cycle events that the register stage latches.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    sample    = 1'b0;
    ovr_start = 1'b0;
    done_d    = 1'b0;
    len_d     = 1'b0;
    tmo_d     = 1'b0;
    drop_d    = TRIG_REQ && ((state_q != S_IDLE) || !ENABLE);

    case (state_q)
      S_IDLE: begin
        if (TRIG_REQ) begin
          state_d = S_TRIG;
          start   = 1'b1;
        end
      end
      S_TRIG: begin
        // The first framed bit may arrive while TRIGGER is still high.
        if (ENABLE_XFR) begin
          state_d = S_XFR;
          sample  = 1'b1;
        end else if (phase_cnt == TW_LAST) begin
          state_d = S_WAIT_XFR;
        end
      end
      S_WAIT_XFR: begin
        if (ENABLE_XFR) begin
          state_d = S_XFR;
          sample  = 1'b1;
        end else if (tmo_cnt == TO_LAST) begin
          state_d = S_HOLD;
          tmo_d   = 1'b1;
        end
      end
      S_XFR: begin
        if (!ENABLE_XFR) begin
          state_d = S_HOLD;
          // An overrun has already been reported; end quietly.
          if (!overrun) begin
            if ((WORD_COUNT == WC_FULL) && (bit_cnt == 4'd0)) done_d = 1'b1;
            else                                                len_d  = 1'b1;
          end
        end else if (!overrun) begin
          if (WORD_COUNT == WC_FULL) begin
            ovr_start = 1'b1;
            len_d     = 1'b1;
          end else begin
            sample = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (phase_cnt == HO_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Software disable wins over everything and suppresses all events.
    if (!ENABLE) begin
      state_d   = S_IDLE;
      start     = 1'b0;
      sample    = 1'b0;
      ovr_start = 1'b0;
      done_d    = 1'b0;
      len_d     = 1'b0;
      tmo_d     = 1'b0;
    end
  end

  assign word_end = sample && (bit_cnt == PAR_BIT);

  // Control, status and output register stage.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      phase_cnt   <= '0;
      tmo_cnt     <= '0;
      bit_cnt     <= '0;
      overrun     <= 1'b0;
      TRIGGER     <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      LEN_ERR     <= 1'b0;
      TRIG_DROP   <= 1'b0;
      WORD_COUNT  <= '0;
      PAR_ERR0    <= '0;
      PAR_ERR1    <= '0;
`ifdef RD_SEQ_DATA_OUT_EN
      RD_DATA0    <= '0;
      RD_DATA1    <= '0;
      RD_PAR_OK   <= '0;
      RD_ADDR     <= '0;
      RD_VALID    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_cnt   <= (state_d != state_q) ? '0 : phase_cnt + PH_W'(1);
      TRIGGER     <= (state_d == S_TRIG);
      BUSY        <= (state_d != S_IDLE);
      DONE        <= done_d;
      TIMEOUT_ERR <= tmo_d;
      LEN_ERR     <= len_d;
      TRIG_DROP   <= drop_d;

      if (start) begin
        tmo_cnt <= '0;
      end else if ((state_q == S_TRIG) || (state_q == S_WAIT_XFR)) begin
        tmo_cnt <= tmo_cnt + TO_W'(1);
      end

      if (start) begin
        WORD_COUNT <= '0;
        PAR_ERR0   <= '0;
        PAR_ERR1   <= '0;
        bit_cnt    <= '0;
        overrun    <= 1'b0;
      end else begin
        if (ovr_start) overrun <= 1'b1;
        if (word_end) begin
          bit_cnt    <= '0;
          WORD_COUNT <= WORD_COUNT + WC_W'(1);
          // A good word has an odd number of ones across all 13 bits.
          if (!(par0 ^ SERIAL_IN0)) PAR_ERR0 <= sat_inc16(PAR_ERR0);
          if (!(par1 ^ SERIAL_IN1)) PAR_ERR1 <= sat_inc16(PAR_ERR1);
        end else if (sample) begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end

`ifdef RD_SEQ_DATA_OUT_EN
      RD_VALID <= word_end;
      if (word_end) begin
        RD_DATA0  <= sh0;
        RD_DATA1  <= sh1;
        RD_PAR_OK <= {par1 ^ SERIAL_IN1, par0 ^ SERIAL_IN0};
        RD_ADDR   <= WORD_COUNT[WC_W-2:0];
      end
`endif
    end
  end

  // Deserializer stage: data bits only, no reset needed.
  always_ff @(posedge CLK) begin
    if (sample && (bit_cnt != PAR_BIT)) begin
      par0 <= (bit_cnt == 4'd0) ? SERIAL_IN0 : (par0 ^ SERIAL_IN0);
      par1 <= (bit_cnt == 4'd0) ? SERIAL_IN1 : (par1 ^ SERIAL_IN1);
`ifdef RD_SEQ_DATA_OUT_EN
      sh0  <= {sh0[10:0], SERIAL_IN0};
      sh1  <= {sh1[10:0], SERIAL_IN1};
`endif
    end
  end

endmodule
